// File: rtl/vedic_mac_accumulator.sv
// vedic_mac_accumulator: pipelined MAC stage that registers operand pairs into an
// external vedic_32x32 multiplier and accumulates the returned products per group.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready        operand stream handshake (in_ready is combinational)
//   in_a, in_b, in_last      operand pair and end-of-group marker
//   mul_a, mul_b             registered operands driven to the multiplier
//   mul_product              combinational product returned by the multiplier
//   out_valid/out_ready      result handshake
//   out_acc                  group sum of products, mod 2^ACC_W
//   out_count                terms in the group, saturating
//   out_overflow             some addition in the group carried out of ACC_W
module vedic_mac_accumulator #(
    parameter int ACC_W = 72,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic             in_last,
    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    input  logic [63:0]      mul_product,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_count,
    output logic             out_overflow
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t           state_q, state_d;
    logic [31:0]      mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic             s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
    logic [ACC_W-1:0] acc_q, acc_d, out_acc_q, out_acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, out_count_q, out_count_d;
    logic             ovf_q, ovf_d, out_overflow_q, out_overflow_d;
    logic             out_valid_q, out_valid_d;

    logic             accept, first, ovf_next;
    logic [ACC_W-1:0] acc_base;
    logic [ACC_W:0]   sum;
    logic [CNT_W-1:0] cnt_next;

    // Holding off while a last term sits in stage 1 keeps the next group from
    // starting before the current result has been handed over.
    assign in_ready = !rst && state_q != DONE && !(s1_valid_q && s1_last_q);
    assign accept   = in_valid && in_ready;
    assign first    = state_q == IDLE;
    assign acc_base = first ? '0 : acc_q;
    assign sum      = {1'b0, acc_base} + {{(ACC_W - 63){1'b0}}, mul_product};
    assign cnt_next = first ? CNT_W'(1) : (&cnt_q ? cnt_q : cnt_q + CNT_W'(1));
    assign ovf_next = (!first && ovf_q) || sum[ACC_W];

    always_comb begin
        state_d        = state_q;
        mul_a_d        = accept ? in_a : mul_a_q;
        mul_b_d        = accept ? in_b : mul_b_q;
        s1_valid_d     = accept;
        s1_last_d      = accept && in_last;
        acc_d          = acc_q;
        cnt_d          = cnt_q;
        ovf_d          = ovf_q;
        out_acc_d      = out_acc_q;
        out_count_d    = out_count_q;
        out_overflow_d = out_overflow_q;
        out_valid_d    = out_valid_q;
        if (s1_valid_q && s1_last_q) begin
            out_acc_d      = sum[ACC_W-1:0];
            out_count_d    = cnt_next;
            out_overflow_d = ovf_next;
            out_valid_d    = 1'b1;
            state_d        = DONE;
            acc_d          = '0;
            cnt_d          = '0;
            ovf_d          = 1'b0;
        end else if (s1_valid_q) begin
            acc_d   = sum[ACC_W-1:0];
            cnt_d   = cnt_next;
            ovf_d   = ovf_next;
            state_d = ACCUM;
        end
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            mul_a_q        <= '0;
            mul_b_q        <= '0;
            s1_valid_q     <= 1'b0;
            s1_last_q      <= 1'b0;
            acc_q          <= '0;
            cnt_q          <= '0;
            ovf_q          <= 1'b0;
            out_acc_q      <= '0;
            out_count_q    <= '0;
            out_overflow_q <= 1'b0;
            out_valid_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            mul_a_q        <= mul_a_d;
            mul_b_q        <= mul_b_d;
            s1_valid_q     <= s1_valid_d;
            s1_last_q      <= s1_last_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            ovf_q          <= ovf_d;
            out_acc_q      <= out_acc_d;
            out_count_q    <= out_count_d;
            out_overflow_q <= out_overflow_d;
            out_valid_q    <= out_valid_d;
        end
    end

    assign mul_a        = mul_a_q;
    assign mul_b        = mul_b_q;
    assign out_valid    = out_valid_q;
    assign out_acc      = out_acc_q;
    assign out_count    = out_count_q;
    assign out_overflow = out_overflow_q;
endmodule

// File: tb/tb_vedic_mac_accumulator.sv
// tb_vedic_mac_accumulator: directed and random checks of the MAC stage at ACC_W=72 and ACC_W=64.
module tb_vedic_mac_accumulator;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_last, out_ready;
    logic [31:0] in_a, in_b;

    logic        in_ready_w, out_valid_w, out_overflow_w;
    logic [31:0] mul_a_w, mul_b_w;
    logic [63:0] mul_p_w;
    logic [71:0] out_acc_w;
    logic [15:0] out_count_w;

    logic        in_ready_n, out_valid_n, out_overflow_n;
    logic [31:0] mul_a_n, mul_b_n;
    logic [63:0] mul_p_n;
    logic [63:0] out_acc_n;
    logic [15:0] out_count_n;

    always #5 clk = ~clk;

    assign mul_p_w = 64'(mul_a_w) * 64'(mul_b_w);
    assign mul_p_n = 64'(mul_a_n) * 64'(mul_b_n);

    vedic_mac_accumulator dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .mul_a(mul_a_w), .mul_b(mul_b_w), .mul_product(mul_p_w),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_acc(out_acc_w),
        .out_count(out_count_w), .out_overflow(out_overflow_w)
    );

    vedic_mac_accumulator #(.ACC_W(64)) dut_n (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_n),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .mul_a(mul_a_n), .mul_b(mul_b_n), .mul_product(mul_p_n),
        .out_valid(out_valid_n), .out_ready(out_ready), .out_acc(out_acc_n),
        .out_count(out_count_n), .out_overflow(out_overflow_n)
    );

    typedef struct {
        logic [127:0] sum;
        int           cnt;
    } res_t;

    res_t         exp_q[$];
    logic [127:0] gsum;
    int           gcnt;
    int           checks = 0;
    int           failures = 0;
    bit           rdy_rand = 1'b0;
    bit           rdy_fix = 1'b1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, sample 1 time unit later,
    // score a result handshake and record an accepted beat in the model.
    task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic last, output logic took);
        res_t r;
        @(negedge clk);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_last   = last;
        out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
        #1;
        if (out_valid_w && out_ready) begin
            chk("pending_result", 128'(exp_q.size()), 128'd1);
            if (exp_q.size() != 0) begin
                r = exp_q.pop_front();
                chk("acc72", 128'(out_acc_w), 128'(r.sum[71:0]));
                chk("ovf72", 128'(out_overflow_w), 128'(|r.sum[127:72]));
                chk("cnt72", 128'(out_count_w), 128'(r.cnt > 65535 ? 65535 : r.cnt));
                chk("vld64", 128'(out_valid_n), 128'd1);
                chk("acc64", 128'(out_acc_n), 128'(r.sum[63:0]));
                chk("ovf64", 128'(out_overflow_n), 128'(|r.sum[127:64]));
                chk("cnt64", 128'(out_count_n), 128'(r.cnt > 65535 ? 65535 : r.cnt));
            end
        end
        took = v && in_ready_w;
        if (took) begin
            gsum = gsum + 128'(a) * 128'(b);
            gcnt++;
            if (last) begin
                exp_q.push_back('{sum: gsum, cnt: gcnt});
                gsum = '0;
                gcnt = 0;
            end
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic last);
        logic took = 1'b0;
        for (int i = 0; i < 64 && !took; i++) cycle(1'b1, a, b, last, took);
        chk("send_accepted", 128'(took), 128'd1);
    endtask

    task automatic idle(input int n);
        logic took;
        for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 32'd0, 1'b0, took);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"}, 128'(in_ready_w), 128'd0);
        chk({tag, "_in_ready64"}, 128'(in_ready_n), 128'd0);
        chk({tag, "_out_valid"}, 128'(out_valid_w), 128'd0);
        chk({tag, "_out_acc"}, 128'(out_acc_w), 128'd0);
        chk({tag, "_out_count"}, 128'(out_count_w), 128'd0);
        chk({tag, "_out_ovf"}, 128'(out_overflow_w), 128'd0);
        chk({tag, "_mul_a"}, 128'(mul_a_w), 128'd0);
        chk({tag, "_mul_b"}, 128'(mul_b_w), 128'd0);
    endtask

    initial begin
        logic        took;
        logic [71:0] held;
        int          n;
        logic [31:0] ra, rb;
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_last = 1'b0;
        out_ready = 1'b1;
        gsum = '0;
        gcnt = 0;
        repeat (2) @(negedge clk);
        #1 chk_reset("por");
        @(negedge clk);
        rst = 1'b0;
        #1 chk("ready_after_release", 128'(in_ready_w), 128'd1);

        // Single term, result held to check latency and values.
        rdy_fix = 1'b0;
        send(32'h2, 32'h3, 1'b1);
        idle(1);
        chk("single_latency_valid", 128'(out_valid_w), 128'd0);
        chk("single_latency_ready", 128'(in_ready_w), 128'd0);
        idle(1);
        chk("single_valid", 128'(out_valid_w), 128'd1);
        chk("single_acc", 128'(out_acc_w), 128'd6);
        chk("single_cnt", 128'(out_count_w), 128'd1);
        chk("single_ovf", 128'(out_overflow_w), 128'd0);
        rdy_fix = 1'b1;
        idle(1);
        idle(1);
        chk("ready_after_handshake", 128'(in_ready_w), 128'd1);
        chk("valid_after_handshake", 128'(out_valid_w), 128'd0);

        // Two-term group sent back to back.
        rdy_fix = 1'b0;
        cycle(1'b1, 32'hFFFFFFFF, 32'h1, 1'b0, took);
        chk("b2b_first", 128'(took), 128'd1);
        cycle(1'b1, 32'h12345678, 32'h87654321, 1'b1, took);
        chk("b2b_second", 128'(took), 128'd1);
        idle(2);
        chk("two_acc", 128'(out_acc_w), 128'h09A0CD0670B88D77);
        chk("two_cnt", 128'(out_count_w), 128'd2);

        // Back-pressure: result held while a new beat is offered.
        held = out_acc_w;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 32'h7, 32'h9, 1'b1, took);
            chk("bp_in_ready", 128'(in_ready_w), 128'd0);
            chk("bp_out_acc", 128'(out_acc_w), 128'(held));
            chk("bp_out_valid", 128'(out_valid_w), 128'd1);
        end
        rdy_fix = 1'b1;
        send(32'h7, 32'h9, 1'b1);
        idle(3);
        chk("bp_drained", 128'(exp_q.size()), 128'd0);

        // Overflow at 64 bits, none at 72 bits.
        rdy_fix = 1'b0;
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        idle(2);
        chk("ovf_acc64", 128'(out_acc_n), 128'hFFFFFFFC00000002);
        chk("ovf_flag64", 128'(out_overflow_n), 128'd1);
        chk("ovf_acc72", 128'(out_acc_w), 128'h1FFFFFFFC00000002);
        chk("ovf_flag72", 128'(out_overflow_w), 128'd0);
        rdy_fix = 1'b1;
        idle(1);
        rdy_fix = 1'b0;
        send(32'h5, 32'h5, 1'b1);
        idle(2);
        chk("ovf_cleared64", 128'(out_overflow_n), 128'd0);
        chk("ovf_next_acc64", 128'(out_acc_n), 128'd25);
        rdy_fix = 1'b1;
        idle(1);

        // Reset in the middle of a group.
        send(32'h3, 32'h4, 1'b0);
        send(32'h5, 32'h6, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        #1 chk_reset("midrst");
        gsum = '0;
        gcnt = 0;
        exp_q.delete();
        @(negedge clk);
        #1 chk("midrst_hold_valid", 128'(out_valid_w), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("midrst_release_ready", 128'(in_ready_w), 128'd1);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("midrst_no_pulse", 128'(out_valid_w), 128'd0);
        end
        rdy_fix = 1'b0;
        send(32'hABCDEF01, 32'h01020304, 1'b1);
        idle(2);
        chk("midrst_acc", 128'(out_acc_w), 128'h00AD2790F806BF04);
        chk("midrst_cnt", 128'(out_count_w), 128'd1);
        rdy_fix = 1'b1;
        idle(1);

        // Streaming: random groups against the model.
        rdy_rand = 1'b1;
        for (int g = 0; g < 100; g++) begin
            n = $urandom_range(1, 8);
            for (int t = 0; t < n; t++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                ra = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
                rb = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
                send(ra, rb, 1'(t == n - 1));
            end
        end
        rdy_rand = 1'b0;
        rdy_fix = 1'b1;
        idle(4);
        chk("stream_drained", 128'(exp_q.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vedic_mac_accumulator.md
# vedic_mac_accumulator

Pipelined multiply-accumulate stage built around `vedic_32x32`. It accepts operand pairs over a valid/ready stream and drives them, registered, into the combinational multiplier. It then sums the returned 64-bit products into a wide accumulator and emits one result per group of terms, where a group is delimited by `in_last`. It sits between the operand source and the result consumer. The multiplier is external and connected through the `mul_*` ports.

## Interface
- `ACC_W`, default 72: accumulator and result width, must be ≥ 64.
- `CNT_W`, default 16: width of the term counter.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block can accept an operand pair this cycle.
- `in_a`  in  32  multiplicand.
- `in_b`  in  32  multiplier.
- `in_last`  in  1  this pair is the final term of its group.
- `mul_a`  out  32  registered operand to `vedic_32x32.a`.
- `mul_b`  out  32  registered operand to `vedic_32x32.b`.
- `mul_product`  in  64  `vedic_32x32.product`, valid in the same cycle as `mul_a`/`mul_b`.
- `out_valid`  out  1  group result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_acc`  out  ACC_W  sum of all group products, mod 2^ACC_W.
- `out_count`  out  CNT_W  number of terms in the group, saturating at 2^CNT_W−1.
- `out_overflow`  out  1  sticky: some addition in the group carried out of ACC_W.

## Operation
- States:
  - IDLE: no term of the current group accepted yet.
  - ACCUM: at least one term accepted, last not yet accepted.
  - DONE: `out_valid`=1, holding the result.
- Accept: a beat transfers on a rising edge where `in_valid` && `in_ready`. At that edge:
  - `mul_a`/`mul_b` ← `in_a`/`in_b`.
  - stage-1 flag `s1_valid` ← 1.
  - `s1_last` ← `in_last`.
  - On no transfer, `s1_valid` ← 0 and `mul_a`/`mul_b` hold their value.
- Accumulate: on an edge with `s1_valid`=1:
  - sum = (first term of group ? 0 : acc) + zero-extended `mul_product`, taken over ACC_W+1 bits.
  - acc ← sum[ACC_W−1:0].
  - overflow ← (first ? 0 : overflow) | sum[ACC_W].
  - count ← (first ? 1 : count+1), saturating at 2^CNT_W−1.
  - "First" is true when the state is IDLE at that edge.
- Result: on the accumulate edge, if `s1_last`=1:
  - `out_acc`, `out_count` and `out_overflow` load the updated values.
  - `out_valid` ← 1, state → DONE.
  - The internal acc, count and overflow clear.
- State transitions:
  - IDLE → ACCUM on an accumulate edge with `s1_last`=0.
  - IDLE/ACCUM → DONE on an accumulate edge with `s1_last`=1.
  - DONE → IDLE on the edge where `out_valid` && `out_ready`. That edge also sets `out_valid` ← 0.
- `in_ready` = !`rst` && state≠DONE && !(`s1_valid` && `s1_last`). This is combinational and prevents a new group from starting before the previous result has been taken.
- `out_acc`, `out_count` and `out_overflow` are stable while `out_valid`=1 and `out_ready`=0.
- A single-term group (first beat has `in_last`=1) is legal: the product is the result, `out_count`=1 and `out_overflow`=0.

## Timing
- Reset, asynchronous: every output and every register goes to 0, state → IDLE. While `rst`=1, `in_ready`=0. In the first cycle after release, `in_ready`=1.
- Throughput: 1 term per cycle inside a group.
- Latency: a last term accepted at edge E gives `out_valid`=1 after edge E+1.
- Group gap: after the result handshake at edge H, `in_ready`=1 from H onward. The first beat of the next group is accepted no earlier than edge H+1, which is one bubble.
- Reset mid-group or in DONE drops the partial sum and the pending result. No output pulse occurs.
- `mul_product` is sampled only on edges with `s1_valid`=1; its value is don't-care otherwise.

## Test plan
- **Single term:** a=0x2, b=0x3, `in_last`=1.
  - After edge E+1: `out_valid`=1, `out_acc`=6, `out_count`=1, `out_overflow`=0.
- **Two-term group:** back-to-back beats (0xFFFFFFFF, 0x1) then (0x12345678, 0x87654321) with `in_last` on the second.
  - `out_acc`=0x09A0CD0670B88D77, `out_count`=2.
- **Back-pressure:** after a result, hold `out_ready`=0 for 5 cycles with `in_valid`=1.
  - `in_ready`=0 throughout and `out_acc` is unchanged.
  - After the handshake, the next group is accepted and no beat is lost or duplicated.
- **Overflow, ACC_W=64:** two beats of (0xFFFFFFFF, 0xFFFFFFFF).
  - `out_acc`=0xFFFFFFFC00000002, `out_overflow`=1.
  - The next single-term group reports `out_overflow`=0.
- **Reset mid-group:** accept 2 non-last terms, pulse `rst`.
  - All outputs read 0 during the pulse and `out_valid` never rises.
  - Then send (0xABCDEF01, 0x01020304) with `in_last`=1: `out_acc`=0x00AD2790F806BF04, `out_count`=1.
- **Streaming:** 100 random groups of 1–8 terms with random `out_ready`.
  - Each `out_acc`/`out_count` matches a reference model computing sum(a·b) mod 2^ACC_W.
